multich_delay_beamformer: RTL and testbench

- Parametrised multi-channel delay-and-sum beamformer; successor to the single-stream BRAM beamformer.
- Holds NUM_CH input sample memories and a per-channel integer delay table. Each output sample is the signed sum of all channels, each read at its own delay.
- Writes results into an internal output RAM that the host/display side reads through a sync read port.
- Start/busy/done handshake replaces the external slice_state sequencing.

---
 rtl/multich_delay_beamformer.sv | 211 +++++++++++++++++++++
 tb/tb_multich_delay_beamformer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multich_delay_beamformer.sv
// Multi-channel delay-and-sum beamformer.
// Each channel has its own sample memory and a delay entry. For every output
// sample n, channel ch is read at address n - delay[ch], or contributes 0 when
// n < delay[ch]. The signed sum of all channels goes into an output RAM, which
// the host reads through a synchronous read port.
// Optional build macro BEAMFORMER_AVG_EN: store the channel mean instead of the sum.
module multich_delay_beamformer #(
  parameter int DATA_W  = 12,
  parameter int NUM_CH  = 4,
  parameter int DEPTH   = 2048,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int DELAY_W = 8,
  parameter int OUT_W   = DATA_W + $clog2(NUM_CH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ADDR_W:0]           num_samples,
  output logic                      busy,
  output logic                      done,
  input  logic                      wr_en,
  input  logic [$clog2(NUM_CH)-1:0] wr_ch,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      delay_we,
  input  logic [$clog2(NUM_CH)-1:0] delay_ch,
  input  logic [DELAY_W-1:0]        delay_val,
  output logic                      out_valid,
  input  logic                      rd_en,
  input  logic [ADDR_W-1:0]         rd_addr,
  output logic [OUT_W-1:0]          rd_data
);

  localparam int CH_W = $clog2(NUM_CH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                    state_r;
  state_t                    state_s;
  logic [CH_W-1:0]           ch_r;
  logic [ADDR_W-1:0]         n_r;
  logic [ADDR_W:0]           count_r;
  logic signed [OUT_W-1:0]   acc_r;
  logic [DELAY_W-1:0]        delay_r [NUM_CH];
  logic [DATA_W-1:0]         in_mem [NUM_CH][DEPTH];
  logic [OUT_W-1:0]          out_mem [DEPTH];
  logic [DATA_W-1:0]         smp_r;
  logic                      smp_vld_r;
  logic                      smp_zero_r;
  logic                      busy_s;
  logic                      done_s;
  logic                      valid_s;
  logic                      last_n_s;
  logic [ADDR_W:0]           clamp_s;
  logic [ADDR_W-1:0]         rd_ptr_s;
  logic signed [OUT_W-1:0]   add_s;
  logic [OUT_W-1:0]          wdata_s;

  // Sample count clamp, channel read address and last-sample detection
  always_comb begin
    clamp_s = num_samples;
    if (num_samples > (ADDR_W+1)'(DEPTH)) begin
      clamp_s = (ADDR_W+1)'(DEPTH);
    end else begin
      clamp_s = num_samples;
    end
    rd_ptr_s = n_r - ADDR_W'(delay_r[ch_r]);
    last_n_s = ({1'b0, n_r} == (count_r - (ADDR_W+1)'(1)));
  end

  // Returned sample sign-extended, or zeroed when the delay reaches before address 0
  always_comb begin
    add_s = {OUT_W{1'b0}};
    if (smp_zero_r) begin
      add_s = {OUT_W{1'b0}};
    end else begin
      add_s = {{(OUT_W-DATA_W){smp_r[DATA_W-1]}}, smp_r};
    end
  end

  // Value stored into the output RAM: channel mean or full sum
  always_comb begin
`ifdef BEAMFORMER_AVG_EN
    wdata_s = acc_r >>> CH_W;
`else
    wdata_s = acc_r;
`endif
  end

  // FSM state register and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_r   <= state_s;
      busy      <= busy_s;
      done      <= done_s;
      out_valid <= valid_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          if (clamp_s == {(ADDR_W+1){1'b0}}) begin
            state_s = S_DONE;
          end else begin
            state_s = S_READ;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_READ: begin
        if (ch_r == CH_W'(NUM_CH-1)) begin
          state_s = S_DRAIN;
        end else begin
          state_s = S_READ;
        end
      end
      S_DRAIN: state_s = S_WRITE;
      S_WRITE: begin
        if (last_n_s) begin
          state_s = S_DONE;
        end else begin
          state_s = S_READ;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Status outputs decoded from the upcoming state so they register in step with it
  always_comb begin
    busy_s  = (state_s != S_IDLE);
    done_s  = (state_s == S_DONE);
    valid_s = (state_s == S_WRITE);
  end

  // Counters, accumulator, read-pipeline flags and delay table
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_r       <= {CH_W{1'b0}};
      n_r        <= {ADDR_W{1'b0}};
      count_r    <= {(ADDR_W+1){1'b0}};
      acc_r      <= {OUT_W{1'b0}};
      smp_vld_r  <= 1'b0;
      smp_zero_r <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        delay_r[i] <= {DELAY_W{1'b0}};
      end
    end else begin
      smp_vld_r  <= (state_r == S_READ);
      smp_zero_r <= (n_r < ADDR_W'(delay_r[ch_r]));
      if (state_r == S_READ) begin
        ch_r <= ch_r + CH_W'(1);
      end else begin
        ch_r <= {CH_W{1'b0}};
      end
      if (state_r == S_IDLE && start) begin
        count_r <= clamp_s;
        n_r     <= {ADDR_W{1'b0}};
        acc_r   <= {OUT_W{1'b0}};
      end else if (state_r == S_WRITE) begin
        acc_r <= {OUT_W{1'b0}};
        if (!last_n_s) begin
          n_r <= n_r + ADDR_W'(1);
        end
      end else if (smp_vld_r) begin
        acc_r <= acc_r + add_s;
      end
      if (state_r == S_IDLE && delay_we) begin
        delay_r[delay_ch] <= delay_val;
      end
    end
  end

  // Sample memories and output RAM writes; channel sample read
  always_ff @(posedge clk) begin
    if (wr_en && state_r == S_IDLE) begin
      in_mem[wr_ch][wr_addr] <= wr_data;
    end
    smp_r <= in_mem[ch_r][rd_ptr_s];
    if (state_r == S_WRITE) begin
      out_mem[n_r] <= wdata_s;
    end
  end

  // Host read port: one-cycle latency, holds when not enabled, old data on collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= {OUT_W{1'b0}};
    end else if (rd_en) begin
      rd_data <= out_mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_multich_delay_beamformer.sv
// Self-checking bench for multich_delay_beamformer.
// The reference model keeps per-channel sample arrays and the delay table, and
// computes every output as a plain sum of the delayed samples.
module tb_multich_delay_beamformer;

  localparam int DATA_W  = 12;
  localparam int NUM_CH  = 4;
  localparam int DEPTH   = 2048;
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int DELAY_W = 8;
  localparam int OUT_W   = DATA_W + $clog2(NUM_CH);
  localparam int CH_W    = $clog2(NUM_CH);

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic [ADDR_W:0]      num_samples;
  logic                 busy;
  logic                 done;
  logic                 wr_en;
  logic [CH_W-1:0]      wr_ch;
  logic [ADDR_W-1:0]    wr_addr;
  logic [DATA_W-1:0]    wr_data;
  logic                 delay_we;
  logic [CH_W-1:0]      delay_ch;
  logic [DELAY_W-1:0]   delay_val;
  logic                 out_valid;
  logic                 rd_en;
  logic [ADDR_W-1:0]    rd_addr;
  logic [OUT_W-1:0]     rd_data;

  int checks = 0;
  int errors = 0;

  int m_mem   [NUM_CH][DEPTH];
  int m_delay [NUM_CH];

  multich_delay_beamformer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .busy(busy), .done(done), .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr),
    .wr_data(wr_data), .delay_we(delay_we), .delay_ch(delay_ch),
    .delay_val(delay_val), .out_valid(out_valid), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Delay-and-sum of the model contents for output sample n
  function automatic logic [OUT_W-1:0] exp_out(input int n);
    int s;
    s = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (n >= m_delay[c]) s += m_mem[c][n - m_delay[c]];
    end
`ifdef BEAMFORMER_AVG_EN
    s = s >>> CH_W;
`endif
    return s[OUT_W-1:0];
  endfunction

  task automatic write_mem(input int ch, input int addr, input int val);
    wr_en = 1'b1; wr_ch = ch[CH_W-1:0]; wr_addr = addr[ADDR_W-1:0];
    wr_data = val[DATA_W-1:0];
    tick();
    wr_en = 1'b0;
    m_mem[ch][addr] = val;
  endtask

  task automatic set_delay(input int ch, input int val);
    delay_we = 1'b1; delay_ch = ch[CH_W-1:0]; delay_val = val[DELAY_W-1:0];
    tick();
    delay_we = 1'b0;
    m_delay[ch] = val;
  endtask

  task automatic fill_random(input int cnt);
    for (int c = 0; c < NUM_CH; c++)
      for (int a = 0; a < cnt; a++)
        write_mem(c, a, int'($urandom_range(0, 4095)) - 2048);
  endtask

  task automatic read_out(input int addr, output logic [OUT_W-1:0] d);
    rd_en = 1'b1; rd_addr = addr[ADDR_W-1:0];
    tick();
    d = rd_data;
    rd_en = 1'b0;
  endtask

  // Starts a run and observes it for a bounded number of cycles (cycle 1 follows the start edge)
  task automatic run_op(input int cnt_req, input bit inject, output int done_cyc,
                        output int nvalid, output int ndone, output int nbusy);
    int eff;
    int budget;
    int cyc;
    eff = (cnt_req > DEPTH) ? DEPTH : cnt_req;
    budget = eff * (NUM_CH + 2) + 12;
    done_cyc = -1; nvalid = 0; ndone = 0; nbusy = 0;
    num_samples = cnt_req[ADDR_W:0];
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (cyc <= budget) begin
      if (busy) nbusy++;
      if (out_valid) nvalid++;
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (inject && cyc == 2) begin
        start = 1'b1; wr_en = 1'b1; wr_ch = '0; wr_addr = '0; wr_data = 12'd55;
        delay_we = 1'b1; delay_ch = 2'd1; delay_val = 8'd9;
      end else if (inject && cyc == 3) begin
        start = 1'b0; wr_en = 1'b0; delay_we = 1'b0;
      end
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
    rst_n = 1'b1;
    tick(); tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got busy=%b done=%b expected 0 0", busy, done); end
  endtask

  task automatic test_zero_delay();
    int dc, nv, nd, nb;
    logic [OUT_W-1:0] d;
    logic [OUT_W-1:0] held;
    // delay table left at its reset value of zero
    for (int c = 0; c < NUM_CH; c++)
      for (int a = 0; a < 8; a++) write_mem(c, a, a);
    run_op(8, 1'b0, dc, nv, nd, nb);
    checks++; if (dc != 49) begin errors++; $display("FAIL zd_done_cycle: got %0d expected 49", dc); end
    checks++; if (nv != 8) begin errors++; $display("FAIL zd_valid_count: got %0d expected 8", nv); end
    checks++; if (nd != 1) begin errors++; $display("FAIL zd_done_count: got %0d expected 1", nd); end
    checks++; if (nb != 49) begin errors++; $display("FAIL zd_busy_cycles: got %0d expected 49", nb); end
    for (int n = 0; n < 8; n++) begin
      read_out(n, d);
      checks++; if (d !== exp_out(n)) begin errors++; $display("FAIL zd_out[%0d]: got %h expected %h", n, d, exp_out(n)); end
    end
    held = exp_out(7);
    rd_addr = 11'd2;
    tick();
    checks++; if (rd_data !== held) begin errors++; $display("FAIL rd_hold: got %h expected %h", rd_data, held); end
  endtask

  task automatic test_staggered();
    int dc, nv, nd, nb;
    logic [OUT_W-1:0] d;
    for (int c = 0; c < NUM_CH; c++) begin
      set_delay(c, c);
      for (int a = 0; a < 6; a++) write_mem(c, a, (a == 0) ? 100 : 0);
    end
    run_op(6, 1'b0, dc, nv, nd, nb);
    checks++; if (dc != 37) begin errors++; $display("FAIL st_done_cycle: got %0d expected 37", dc); end
    for (int n = 0; n < 6; n++) begin
      read_out(n, d);
      checks++; if (d !== exp_out(n)) begin errors++; $display("FAIL st_out[%0d]: got %h expected %h", n, d, exp_out(n)); end
    end
  endtask

  task automatic test_neg_full_scale();
    int dc, nv, nd, nb;
    logic [OUT_W-1:0] d;
    for (int c = 0; c < NUM_CH; c++) begin
      set_delay(c, 0);
      for (int a = 0; a < 4; a++) write_mem(c, a, -2048);
    end
    run_op(4, 1'b0, dc, nv, nd, nb);
    for (int n = 0; n < 4; n++) begin
      read_out(n, d);
      checks++; if (d !== exp_out(n)) begin errors++; $display("FAIL neg_out[%0d]: got %h expected %h", n, d, exp_out(n)); end
    end
  endtask

  task automatic test_busy_ignore();
    int dc, nv, nd, nb;
    logic [OUT_W-1:0] d;
    fill_random(5);
    write_mem(0, 0, -55);
    for (int c = 0; c < NUM_CH; c++) set_delay(c, $urandom_range(0, 2));
    for (int pass = 0; pass < 2; pass++) begin
      run_op(5, (pass == 0), dc, nv, nd, nb);
      checks++; if (nd != 1) begin errors++; $display("FAIL bi_done_count[%0d]: got %0d expected 1", pass, nd); end
      checks++; if (dc != 31 || nv != 5) begin errors++; $display("FAIL bi_timing[%0d]: got done=%0d valid=%0d expected 31 5", pass, dc, nv); end
      for (int n = 0; n < 5; n++) begin
        read_out(n, d);
        checks++; if (d !== exp_out(n)) begin errors++; $display("FAIL bi_out[%0d][%0d]: got %h expected %h", pass, n, d, exp_out(n)); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int dc, nv, nd, nb;
    logic [OUT_W-1:0] d;
    logic [OUT_W-1:0] keep [3];
    fill_random(8);
    for (int c = 0; c < NUM_CH; c++) set_delay(c, $urandom_range(0, 3));
    for (int n = 0; n < 3; n++) keep[n] = exp_out(n);
    num_samples = 12'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc < 21; cyc++) tick();
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_reset_outputs: got busy=%b valid=%b done=%b expected 0 0 0", busy, out_valid, done); end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < NUM_CH; c++) m_delay[c] = 0;
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_reset_idle: got busy=%b done=%b expected 0 0", busy, done); end
    for (int n = 0; n < 3; n++) begin
      read_out(n, d);
      checks++; if (d !== keep[n]) begin errors++; $display("FAIL mid_kept[%0d]: got %h expected %h", n, d, keep[n]); end
    end
    run_op(8, 1'b0, dc, nv, nd, nb);
    checks++; if (dc != 49 || nv != 8 || nd != 1) begin errors++; $display("FAIL mid_rerun: got done=%0d valid=%0d ndone=%0d expected 49 8 1", dc, nv, nd); end
    for (int n = 0; n < 8; n++) begin
      read_out(n, d);
      checks++; if (d !== exp_out(n)) begin errors++; $display("FAIL mid_out[%0d]: got %h expected %h", n, d, exp_out(n)); end
    end
  endtask

  task automatic test_zero_count();
    int dc, nv, nd, nb;
    run_op(0, 1'b0, dc, nv, nd, nb);
    checks++; if (dc != 1) begin errors++; $display("FAIL zc_done_cycle: got %0d expected 1", dc); end
    checks++; if (nv != 0) begin errors++; $display("FAIL zc_valid_count: got %0d expected 0", nv); end
    checks++; if (nb != 1) begin errors++; $display("FAIL zc_busy_cycles: got %0d expected 1", nb); end
  endtask

  task automatic test_random();
    int dc, nv, nd, nb, cnt;
    logic [OUT_W-1:0] d;
    for (int it = 0; it < 4; it++) begin
      cnt = $urandom_range(1, 24);
      fill_random(cnt);
      for (int c = 0; c < NUM_CH; c++) set_delay(c, $urandom_range(0, cnt + 2));
      run_op(cnt, 1'b0, dc, nv, nd, nb);
      checks++; if (dc != cnt * (NUM_CH + 2) + 1 || nv != cnt) begin errors++; $display("FAIL rnd_timing[%0d]: got done=%0d valid=%0d expected %0d %0d", it, dc, nv, cnt * (NUM_CH + 2) + 1, cnt); end
      for (int n = 0; n < cnt; n++) begin
        read_out(n, d);
        checks++; if (d !== exp_out(n)) begin errors++; $display("FAIL rnd_out[%0d][%0d]: got %h expected %h", it, n, d, exp_out(n)); end
      end
    end
  endtask

  task automatic test_clamp();
    int dc, nv, nd, nb, a;
    logic [OUT_W-1:0] d;
    fill_random(DEPTH);
    for (int c = 0; c < NUM_CH; c++) set_delay(c, $urandom_range(0, 255));
    run_op($urandom_range(DEPTH + 1, 2 * DEPTH - 1), 1'b0, dc, nv, nd, nb);
    checks++; if (dc != DEPTH * (NUM_CH + 2) + 1 || nv != DEPTH) begin errors++; $display("FAIL clamp_timing: got done=%0d valid=%0d expected %0d %0d", dc, nv, DEPTH * (NUM_CH + 2) + 1, DEPTH); end
    for (int k = 0; k < 4; k++) begin
      a = (k == 0) ? DEPTH - 1 : $urandom_range(0, DEPTH - 1);
      read_out(a, d);
      checks++; if (d !== exp_out(a)) begin errors++; $display("FAIL clamp_out[%0d]: got %h expected %h", a, d, exp_out(a)); end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; num_samples = '0; wr_en = 1'b0; wr_ch = '0;
    wr_addr = '0; wr_data = '0; delay_we = 1'b0; delay_ch = '0; delay_val = '0;
    rd_en = 1'b0; rd_addr = '0;
    for (int c = 0; c < NUM_CH; c++) m_delay[c] = 0;
    tick(); tick(); tick();
    test_reset();
    test_zero_delay();
    test_staggered();
    test_neg_full_scale();
    test_busy_ignore();
    test_reset_mid();
    test_zero_count();
    test_random();
    test_clamp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
